// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The master drives the op request; the slave returns Busy/Done and the HI/LO registers.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             Start;
    logic [3:0]       MDControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output Start, MDControl, A, B, input Busy, Done, HI, LO);
    modport slave  (input Start, MDControl, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO with a Busy/Done handshake.
// Signed ops run on magnitudes and the sign is applied in a single FIX cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic           Clk,
    input  logic           Rst,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = $clog2(ITER + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MTHI  = 4'b1100;
    localparam logic [3:0] OP_MTLO  = 4'b1101;

    logic [1:0]         state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_a, neg_b, div_zero, done_q;
    logic [WIDTH-1:0]   opnd, acc_hi, acc_lo, hi_q, lo_q;

    logic               start_md, start_signed, start_div;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Request decode and operand magnitudes (two's-complement negate keeps -2^(W-1) exact as unsigned)
    always_comb begin
        start_md     = bus.Start && (bus.MDControl inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
        start_signed = ~bus.MDControl[0];
        start_div    = bus.MDControl[1];
        mag_a        = (start_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        mag_b        = (start_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_md) state_nxt = RUN;
            RUN:     if (cnt == CW'(ITER - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration: acc_hi/acc_lo are product halves for multiply, remainder/quotient for divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        if (is_div) begin
            step_hi = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
        end else begin
            {step_hi, step_lo} = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up; divide by zero forces an all-ones quotient while the remainder returns A
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = div_zero ? {WIDTH{1'b1}} : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
        rem_fix  = neg_a ? -acc_hi : acc_hi;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_md) begin
                        cnt      <= '0;
                        is_div   <= start_div;
                        neg_a    <= start_signed && bus.A[WIDTH-1];
                        neg_b    <= start_signed && bus.B[WIDTH-1];
                        div_zero <= start_div && (bus.B == '0);
                        opnd     <= mag_b;
                        acc_hi   <= '0;
                        acc_lo   <= mag_a;
                    end else if (bus.Start && bus.MDControl == OP_MTHI) begin
                        hi_q <= bus.A;
                    end else if (bus.Start && bus.MDControl == OP_MTLO) begin
                        lo_q <= bus.A;
                    end
                end
                RUN: begin
                    cnt    <= cnt + CW'(1);
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
                FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {HI,LO} queued at issue, compared on Done.
module tb_mult_div_unit;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned LAT   = ITER + 2;

    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MTHI  = 4'b1100;
    localparam logic [3:0] OP_MTLO  = 4'b1101;

    logic Clk = 1'b0;
    logic Rst;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] hl_model;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference result {HI,LO} from native arithmetic
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        case (op)
            OP_MULT:  p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            OP_MULTU: p = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0)                                   p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else p = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            end
            OP_DIVU:  p = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default:  p = '0;
        endcase
        return p;
    endfunction

    // Issue one op, optionally poke a second Start mid-run, then wait for Done and score it
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        int          lat;
        logic [63:0] exp;
        bus.Start = 1'b1; bus.MDControl = op; bus.A = a; bus.B = b;
        sb_q.push_back(model(op, a, b));
        tick();
        bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        check({tag, " busy"}, 64'(bus.Busy), 64'd1);
        lat = 1;
        while (!bus.Done && lat < 80) begin
            tick();
            lat++;
            if (poke && lat == 10) begin
                bus.Start = 1'b1; bus.MDControl = OP_MULTU;
            end
            if (poke && lat == 11) bus.Start = 1'b0;
        end
        exp = sb_q.pop_front();
        check({tag, " done"}, 64'(bus.Done), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " hilo"}, {bus.HI, bus.LO}, exp);
        check({tag, " idle"}, 64'(bus.Busy), 64'd0);
        hl_model = exp;
        tick();
        check({tag, " pulse"}, 64'(bus.Done), 64'd0);
    endtask

    initial begin
        int seen;
        logic [3:0] rop;
        Rst = 1'b0; bus.Start = 1'b0; bus.MDControl = 4'd0; bus.A = '0; bus.B = '0;
        hl_model = '0;
        tick(); tick();
        Rst = 1'b1;
        check("rst busy", 64'(bus.Busy), 64'd0);
        check("rst done", 64'(bus.Done), 64'd0);
        check("rst hilo", {bus.HI, bus.LO}, 64'd0);

        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        run_op("mult",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
        run_op("div",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op("divu",  OP_DIVU,  32'h0000_000F, 32'h0000_0004, 1'b0);
        run_op("divu0", OP_DIVU,  32'h0000_000F, 32'h0000_0000, 1'b0);
        run_op("divovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div0s", OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 1'b0);
        run_op("multmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);

        bus.Start = 1'b1; bus.MDControl = OP_MTHI; bus.A = 32'h1234_5678;
        tick();
        bus.Start = 1'b0;
        hl_model[63:32] = 32'h1234_5678;
        check("mthi hilo", {bus.HI, bus.LO}, hl_model);
        check("mthi busy", 64'(bus.Busy), 64'd0);
        check("mthi done", 64'(bus.Done), 64'd0);

        bus.Start = 1'b1; bus.MDControl = OP_MTLO; bus.A = 32'hCAFE_F00D;
        tick();
        bus.Start = 1'b0;
        hl_model[31:0] = 32'hCAFE_F00D;
        check("mtlo hilo", {bus.HI, bus.LO}, hl_model);

        bus.Start = 1'b1; bus.MDControl = 4'b0000; bus.A = 32'hDEAD_BEEF;
        tick();
        bus.Start = 1'b0;
        check("badop busy", 64'(bus.Busy), 64'd0);
        check("badop hilo", {bus.HI, bus.LO}, hl_model);

        run_op("poke", OP_MULTU, 32'h0001_0003, 32'h0000_0007, 1'b1);

        for (int i = 0; i < 6; i++) begin
            rop = OP_MULT + 4'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", i), rop, $urandom,
                   (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom, 1'b0);
        end

        // Reset in the middle of a multiply abandons it
        bus.Start = 1'b1; bus.MDControl = OP_MULT; bus.A = 32'h0000_0123; bus.B = 32'h0000_0456;
        tick();
        bus.Start = 1'b0;
        repeat (9) tick();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        check("midrst busy", 64'(bus.Busy), 64'd0);
        check("midrst done", 64'(bus.Done), 64'd0);
        check("midrst hilo", {bus.HI, bus.LO}, 64'd0);
        seen = 0;
        repeat (LAT + 4) begin
            tick();
            if (bus.Done) seen++;
        end
        check("midrst nodone", 64'(seen), 64'd0);

        run_op("postrst", OP_DIVU, 32'h0000_0064, 32'h0000_0007, 1'b0);
        check("sb empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
